shift_add_mult_n: RTL and testbench

//  Parametrised sequential shift-and-add multiplier with a start/ready/done handshake.

---
 rtl/shift_add_mult_n_if.sv | 24 ++
 rtl/shift_add_mult_n.sv | 109 ++++++++++
 tb/tb_shift_add_mult_n.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_n_if.sv
// Handshake and operand/result bundle for shift_add_mult_n.
// WIDTH must match the multiplier instance it connects to.
interface shift_add_mult_n_if #(
   parameter int unsigned WIDTH = 4
);
   logic                   start;
   logic                   signed_mode;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   ready;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start, signed_mode, a, b,
      input  ready, busy, done, product
   );

   modport slave (
      input  start, signed_mode, a, b,
      output ready, busy, done, product
   );
endinterface

// File: rtl/shift_add_mult_n.sv
// Sequential N-bit shift-and-add multiplier, one iteration per cycle, with
// optional two's-complement operands handled as sign/magnitude around the core.
module shift_add_mult_n #(
   parameter int unsigned WIDTH = 4
) (
   input logic               clk,
   input logic               reset,
   shift_add_mult_n_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     mag_a_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic                 neg_q;
   logic [2*WIDTH-1:0]   product_q;
   logic                 done_q;
   logic                 busy_q;
   logic                 ready_q;

   logic [WIDTH-1:0]     mag_a_d;
   logic [WIDTH-1:0]     mag_b_d;
   logic                 neg_d;
   logic [WIDTH:0]       sum_d;
   logic [WIDTH-1:0]     hi_d;
   logic [WIDTH-1:0]     lo_d;
   logic [2*WIDTH-1:0]   raw_d;

   always_comb begin
      // -2^(N-1) negates to itself, which read unsigned is exactly its magnitude
      mag_a_d = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b_d = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      neg_d   = bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      sum_d   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
      // carry lands in hi MSB after the right shift
      hi_d    = sum_d[WIDTH:1];
      lo_d    = {sum_d[0], lo_q[WIDTH-1:1]};
      raw_d   = {hi_q, lo_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mag_a_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  mag_a_q <= mag_a_d;
                  lo_q    <= mag_b_d;
                  hi_q    <= '0;
                  neg_q   <= neg_d;
                  cnt_q   <= '0;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               product_q <= neg_q ? -raw_d : raw_d;
               state_q   <= DONE;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               ready_q   <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_mult_n.sv
// Directed bench for shift_add_mult_n at WIDTH=4 and WIDTH=8; expected products
// and start cycles are queued at issue and checked when done pulses.
module tb_shift_add_mult_n;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   shift_add_mult_n_if #(.WIDTH(4)) if4 ();
   shift_add_mult_n_if #(.WIDTH(8)) if8 ();

   shift_add_mult_n #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
   shift_add_mult_n #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {logic [7:0] prod; int c;} e4_t;
   typedef struct {logic [15:0] prod; int c;} e8_t;
   e4_t q4[$];
   e8_t q8[$];
   int dones4 = 0;
   int dones8 = 0;
   logic prev4 = 1'b0;
   logic prev8 = 1'b0;

   function automatic logic [7:0] exp4(input logic [3:0] a, input logic [3:0] b, input logic sm);
      longint x, y;
      if (sm) begin x = $signed(a); y = $signed(b); end
      else begin x = a; y = b; end
      return 8'(x * y);
   endfunction

   function automatic logic [15:0] exp8(input logic [7:0] a, input logic [7:0] b, input logic sm);
      longint x, y;
      if (sm) begin x = $signed(a); y = $signed(b); end
      else begin x = a; y = b; end
      return 16'(x * y);
   endfunction

   always @(negedge clk) begin
      e4_t e;
      if (prev4) begin
         checks++;
         assert (if4.done === 1'b0) else begin errors++; $error("FAIL done4_pulse observed=%b expected=0", if4.done); end
      end
      prev4 = (if4.done === 1'b1);
      if (if4.done === 1'b1) begin
         dones4++;
         checks++;
         assert (q4.size() > 0) else begin errors++; $error("FAIL done4_unexpected observed=%0d expected>0 pending", q4.size()); end
         if (q4.size() > 0) begin
            e = q4.pop_front();
            checks++;
            assert (if4.product === e.prod) else begin errors++; $error("FAIL prod4 observed=%h expected=%h", if4.product, e.prod); end
            checks++;
            assert (cyc - e.c === 6) else begin errors++; $error("FAIL lat4 observed=%0d expected=6", cyc - e.c); end
         end
      end
   end

   always @(negedge clk) begin
      e8_t e;
      if (prev8) begin
         checks++;
         assert (if8.done === 1'b0) else begin errors++; $error("FAIL done8_pulse observed=%b expected=0", if8.done); end
      end
      prev8 = (if8.done === 1'b1);
      if (if8.done === 1'b1) begin
         dones8++;
         checks++;
         assert (q8.size() > 0) else begin errors++; $error("FAIL done8_unexpected observed=%0d expected>0 pending", q8.size()); end
         if (q8.size() > 0) begin
            e = q8.pop_front();
            checks++;
            assert (if8.product === e.prod) else begin errors++; $error("FAIL prod8 observed=%h expected=%h", if8.product, e.prod); end
            checks++;
            assert (cyc - e.c === 10) else begin errors++; $error("FAIL lat8 observed=%0d expected=10", cyc - e.c); end
         end
      end
   end

   // Callers sit at #1 after a rising edge; returns at #1 after the accepting edge.
   task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sm);
      if4.a = a; if4.b = b; if4.signed_mode = sm; if4.start = 1'b1;
      q4.push_back('{prod: exp4(a, b, sm), c: cyc});
      @(posedge clk); #1;
      if4.start = 1'b0;
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm);
      if8.a = a; if8.b = b; if8.signed_mode = sm; if8.start = 1'b1;
      q8.push_back('{prod: exp8(a, b, sm), c: cyc});
      @(posedge clk); #1;
      if8.start = 1'b0;
   endtask

   task automatic wait4();
      int n = 0;
      while (q4.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      assert (q4.size() == 0) else begin errors++; $error("FAIL wait4_timeout observed=%0d expected=0 pending", q4.size()); end
      q4.delete();
   endtask

   task automatic wait8();
      int n = 0;
      while (q8.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      assert (q8.size() == 0) else begin errors++; $error("FAIL wait8_timeout observed=%0d expected=0 pending", q8.size()); end
      q8.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int n;
      if4.start = 1'b0; if4.signed_mode = 1'b0; if4.a = '0; if4.b = '0;
      if8.start = 1'b0; if8.signed_mode = 1'b0; if8.a = '0; if8.b = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; assert (if4.ready === 1'b1) else begin errors++; $error("FAIL rst_ready4 observed=%b expected=1", if4.ready); end
      checks++; assert (if4.busy === 1'b0) else begin errors++; $error("FAIL rst_busy4 observed=%b expected=0", if4.busy); end
      checks++; assert (if4.done === 1'b0) else begin errors++; $error("FAIL rst_done4 observed=%b expected=0", if4.done); end
      checks++; assert (if4.product === 8'h00) else begin errors++; $error("FAIL rst_prod4 observed=%h expected=00", if4.product); end
      checks++; assert (if8.product === 16'h0000) else begin errors++; $error("FAIL rst_prod8 observed=%h expected=0000", if8.product); end
      reset = 1'b0;
      @(posedge clk); #1;

      issue4(4'd15, 4'd15, 1'b0); wait4();
      issue4(4'hD, 4'd5, 1'b1);  wait4();
      issue4(4'h8, 4'h8, 1'b1);  wait4();

      // product must hold the previous +64 through the next RUN; a start here is dropped
      issue4(4'd3, 4'd2, 1'b0);
      checks++; assert (if4.product === 8'h40) else begin errors++; $error("FAIL hold4 observed=%h expected=40", if4.product); end
      checks++; assert (if4.busy === 1'b1) else begin errors++; $error("FAIL busy4 observed=%b expected=1", if4.busy); end
      checks++; assert (if4.ready === 1'b0) else begin errors++; $error("FAIL ready4 observed=%b expected=0", if4.ready); end
      if4.a = 4'd7; if4.b = 4'd7; if4.signed_mode = 1'b1; if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      wait4();
      d = dones4;
      repeat (10) begin @(posedge clk); #1; end
      checks++; assert (dones4 === d) else begin errors++; $error("FAIL ignored_start observed=%0d expected=%0d", dones4, d); end

      // back-to-back: start held in the DONE cycle
      issue4(4'd9, 4'd9, 1'b0);
      n = 0;
      while (if4.done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checks++; assert (if4.done === 1'b1) else begin errors++; $error("FAIL b2b_done observed=%b expected=1", if4.done); end
      issue4(4'hF, 4'h1, 1'b1);
      wait4();

      issue8(8'd255, 8'd255, 1'b0); wait8();
      issue8(8'd0, 8'd200, 1'b0);   wait8();
      issue8(8'h80, 8'h80, 1'b1);   wait8();
      issue8(8'd13, 8'hF6, 1'b1);   wait8();

      // reset in the 3rd RUN cycle aborts without a done pulse
      issue4(4'd5, 4'd6, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      q4.delete();
      d = dones4;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; assert (if4.product === 8'h00) else begin errors++; $error("FAIL abort_prod observed=%h expected=00", if4.product); end
      checks++; assert (if4.busy === 1'b0) else begin errors++; $error("FAIL abort_busy observed=%b expected=0", if4.busy); end
      checks++; assert (if4.ready === 1'b1) else begin errors++; $error("FAIL abort_ready observed=%b expected=1", if4.ready); end
      repeat (12) begin @(posedge clk); #1; end
      checks++; assert (dones4 === d) else begin errors++; $error("FAIL abort_done observed=%0d expected=%0d", dones4, d); end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
